// File: rtl/de10nano_pio_pkg.sv
// Shared constants, register index enum and address decode for the DE10-Nano PIO slave.
package de10nano_pio_pkg;

  localparam int PIO_LED_W_DEF  = 6;
  localparam int PIO_SW_W_DEF   = 4;
  localparam int PIO_KEY_W_DEF  = 2;
  localparam int PIO_GPIO_W_DEF = 32;

  localparam logic [11:0] PIO_LED_OUT   = 12'h000;
  localparam logic [11:0] PIO_SW_IN     = 12'h004;
  localparam logic [11:0] PIO_KEY_IN    = 12'h008;
  localparam logic [11:0] PIO_GPIO0_OUT = 12'h00C;
  localparam logic [11:0] PIO_GPIO0_DIR = 12'h010;
  localparam logic [11:0] PIO_GPIO0_IN  = 12'h014;
  localparam logic [11:0] PIO_GPIO1_OUT = 12'h018;
  localparam logic [11:0] PIO_GPIO1_DIR = 12'h01C;
  localparam logic [11:0] PIO_GPIO1_IN  = 12'h020;

  typedef enum logic [3:0] {
    REG_LED_OUT   = 4'd0,
    REG_SW_IN     = 4'd1,
    REG_KEY_IN    = 4'd2,
    REG_GPIO0_OUT = 4'd3,
    REG_GPIO0_DIR = 4'd4,
    REG_GPIO0_IN  = 4'd5,
    REG_GPIO1_OUT = 4'd6,
    REG_GPIO1_DIR = 4'd7,
    REG_GPIO1_IN  = 4'd8,
    REG_NONE      = 4'd15
  } pio_reg_e;

  // Word index addr[11:2] to register; anything unmapped is REG_NONE.
  function automatic pio_reg_e pio_decode(input logic [9:0] word_addr);
    pio_reg_e sel;
    sel = REG_NONE;
    case (word_addr)
      PIO_LED_OUT[11:2]:   sel = REG_LED_OUT;
      PIO_SW_IN[11:2]:     sel = REG_SW_IN;
      PIO_KEY_IN[11:2]:    sel = REG_KEY_IN;
      PIO_GPIO0_OUT[11:2]: sel = REG_GPIO0_OUT;
      PIO_GPIO0_DIR[11:2]: sel = REG_GPIO0_DIR;
      PIO_GPIO0_IN[11:2]:  sel = REG_GPIO0_IN;
      PIO_GPIO1_OUT[11:2]: sel = REG_GPIO1_OUT;
      PIO_GPIO1_DIR[11:2]: sel = REG_GPIO1_DIR;
      PIO_GPIO1_IN[11:2]:  sel = REG_GPIO1_IN;
      default:             sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/de10nano_pio_if_sync_2ff.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two back-to-back flops; only the second stage is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/de10nano_pio_if.sv
// Memory-mapped LED/switch/key/GPIO slave for the DE10-Nano (region-local addressing).
// Define PIO_SYNC_EN to put 2-flop synchronizers on SW, KEY, GPIO0 and GPIO1 inputs.
module de10nano_pio_if
  import de10nano_pio_pkg::*;
#(
  parameter int LED_W  = PIO_LED_W_DEF,
  parameter int SW_W   = PIO_SW_W_DEF,
  parameter int KEY_W  = PIO_KEY_W_DEF,
  parameter int GPIO_W = PIO_GPIO_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic [LED_W-1:0]  LED,
  input  logic [SW_W-1:0]   SW,
  input  logic [KEY_W-1:0]  KEY,
  inout  wire  [GPIO_W-1:0] GPIO0,
  inout  wire  [GPIO_W-1:0] GPIO1
);

  logic [LED_W-1:0]  led_out_r;
  logic [GPIO_W-1:0] gpio0_out_r;
  logic [GPIO_W-1:0] gpio0_dir_r;
  logic [GPIO_W-1:0] gpio1_out_r;
  logic [GPIO_W-1:0] gpio1_dir_r;
  logic [31:0]       rd_r;
  logic [31:0]       rd_next_s;
  logic [SW_W-1:0]   sw_s;
  logic [KEY_W-1:0]  key_s;
  logic [GPIO_W-1:0] gpio0_in_s;
  logic [GPIO_W-1:0] gpio1_in_s;
  pio_reg_e          reg_sel_s;
  logic              unused_addr_s;

  // Only the word index inside the 4 KiB window matters; the rest aliases.
  assign reg_sel_s     = pio_decode(addr[11:2]);
  assign unused_addr_s = ^{addr[31:12], addr[1:0]};

`ifdef PIO_SYNC_EN
  sync_2ff #(.W(SW_W))   u_sync_sw    (.clk(clk), .rst_n(reset), .d(SW),    .q(sw_s));
  sync_2ff #(.W(KEY_W))  u_sync_key   (.clk(clk), .rst_n(reset), .d(KEY),   .q(key_s));
  sync_2ff #(.W(GPIO_W)) u_sync_gpio0 (.clk(clk), .rst_n(reset), .d(GPIO0), .q(gpio0_in_s));
  sync_2ff #(.W(GPIO_W)) u_sync_gpio1 (.clk(clk), .rst_n(reset), .d(GPIO1), .q(gpio1_in_s));
`else
  assign sw_s       = SW;
  assign key_s      = KEY;
  assign gpio0_in_s = GPIO0;
  assign gpio1_in_s = GPIO1;
`endif

  // Writable registers; writes to read-only or unmapped offsets fall through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out_r   <= '0;
      gpio0_out_r <= '0;
      gpio0_dir_r <= '0;
      gpio1_out_r <= '0;
      gpio1_dir_r <= '0;
    end else if (we) begin
      case (reg_sel_s)
        REG_LED_OUT:   led_out_r   <= wd[LED_W-1:0];
        REG_GPIO0_OUT: gpio0_out_r <= wd[GPIO_W-1:0];
        REG_GPIO0_DIR: gpio0_dir_r <= wd[GPIO_W-1:0];
        REG_GPIO1_OUT: gpio1_out_r <= wd[GPIO_W-1:0];
        REG_GPIO1_DIR: gpio1_dir_r <= wd[GPIO_W-1:0];
        default:       ;
      endcase
    end
  end

  // Read mux, zero-extended; sees pre-write register values.
  always_comb begin
    rd_next_s = 32'h0000_0000;
    case (reg_sel_s)
      REG_LED_OUT:   rd_next_s[LED_W-1:0]  = led_out_r;
      REG_SW_IN:     rd_next_s[SW_W-1:0]   = sw_s;
      REG_KEY_IN:    rd_next_s[KEY_W-1:0]  = key_s;
      REG_GPIO0_OUT: rd_next_s[GPIO_W-1:0] = gpio0_out_r;
      REG_GPIO0_DIR: rd_next_s[GPIO_W-1:0] = gpio0_dir_r;
      REG_GPIO0_IN:  rd_next_s[GPIO_W-1:0] = gpio0_in_s;
      REG_GPIO1_OUT: rd_next_s[GPIO_W-1:0] = gpio1_out_r;
      REG_GPIO1_DIR: rd_next_s[GPIO_W-1:0] = gpio1_dir_r;
      REG_GPIO1_IN:  rd_next_s[GPIO_W-1:0] = gpio1_in_s;
      default:       rd_next_s = 32'h0000_0000;
    endcase
  end

  // Read data register, refreshed every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_r <= 32'h0000_0000;
    end else begin
      rd_r <= rd_next_s;
    end
  end

  assign rd  = rd_r;
  assign LED = led_out_r;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    assign GPIO0[i] = gpio0_dir_r[i] ? gpio0_out_r[i] : 1'bz;
    assign GPIO1[i] = gpio1_dir_r[i] ? gpio1_out_r[i] : 1'bz;
  end

endmodule

// File: tb/tb_de10nano_pio_if.sv
// Directed self-checking bench for de10nano_pio_if; pins are pulled up so high-Z reads as 1.
module tb_de10nano_pio_if;

`ifdef PIO_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [5:0]  led;
  logic [3:0]  sw;
  logic [1:0]  key;
  logic [31:0] g0_oe, g0_val, g1_oe, g1_val;
  wire  [31:0] gpio0_w;
  wire  [31:0] gpio1_w;

  int total;
  int bad;

  de10nano_pio_if dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .LED(led), .SW(sw), .KEY(key), .GPIO0(gpio0_w), .GPIO1(gpio1_w)
  );

  for (genvar i = 0; i < 32; i++) begin : g_tbpin
    assign gpio0_w[i] = g0_oe[i] ? g0_val[i] : 1'bz;
    assign gpio1_w[i] = g1_oe[i] ? g1_val[i] : 1'bz;
    pullup pu0 (gpio0_w[i]);
    pullup pu1 (gpio1_w[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wd = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; we = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    check(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] hist [0:63];
    logic        v;
    total = 0; bad = 0;
    reset = 1'b0; we = 1'b0; addr = 32'h0000_000C; wd = 32'hFFFF_FFFF;
    sw = 4'b0000; key = 2'b00;
    g0_oe = 32'h0; g0_val = 32'h0; g1_oe = 32'h0; g1_val = 32'h0;

    for (int i = 0; i < 4; i++) tick();
    check("rst_led", {26'h0, led}, 32'h0);
    check("rst_rd", rd, 32'h0);
    check("rst_gpio0_z", gpio0_w, 32'hFFFF_FFFF);
    check("rst_gpio1_z", gpio1_w, 32'hFFFF_FFFF);
    reset = 1'b1;
    rd_chk("rd_g0out_rst", 32'h0000_000C, 32'h0);
    rd_chk("rd_g0dir_rst", 32'h0000_0010, 32'h0);

    wr(32'h0000_0000, 32'h0000_00FF);
    check("led_pins", {26'h0, led}, 32'h0000_003F);
    tick();
    check("led_readback", rd, 32'h0000_003F);

    g0_oe = 32'h0000_FFFF; g0_val = 32'h0000_ABCD;
    wr(32'h0000_0010, 32'hFFFF_0000);
    wr(32'h0000_000C, 32'h1234_5678);
    check("gpio0_pins", gpio0_w, 32'h1234_ABCD);
    rd_chk("gpio0_in", 32'h0000_0014, 32'h1234_ABCD);
    rd_chk("gpio0_dir_rb", 32'h0000_0010, 32'hFFFF_0000);
    rd_chk("gpio0_out_rb", 32'h0000_000C, 32'h1234_5678);

    wr(32'h0000_001C, 32'h0000_00FF);
    wr(32'h0000_0018, 32'hA5A5_A5A5);
    check("gpio1_pins", gpio1_w, 32'hFFFF_FFA5);
    rd_chk("gpio1_in", 32'h0000_0020, 32'hFFFF_FFA5);
    rd_chk("gpio1_out_rb", 32'h0000_0018, 32'hA5A5_A5A5);

    // Release the upper half so the bench can toggle bit 17 from outside.
    wr(32'h0000_0010, 32'h0000_0000);
    g0_oe = 32'h0002_FFFF;
    addr = 32'h0000_0014;
    for (int k = 0; k < 30; k++) begin
      v = ((k / 5) % 2) == 1;
      g0_val[17] = v;
      hist[k] = 32'hFFFD_ABCD | ({31'h0, v} << 17);
      tick();
      if (k - LAT + 1 >= 0) check("track_gpio0_17", rd, hist[k - LAT + 1]);
    end

    addr = 32'h0000_0008;
    for (int k = 0; k < 30; k++) begin
      v = ((k / 5) % 2) == 1;
      key = v ? 2'b10 : 2'b01;
      hist[k] = {30'h0, key};
      tick();
      if (k - LAT + 1 >= 0) check("track_key", rd, hist[k - LAT + 1]);
    end

    sw = 4'b0110;
    wr(32'h0000_0004, 32'hFFFF_FFFF);
    rd_chk("sw_ro", 32'h0000_0004, 32'h0000_0006);
    check("sw_wr_no_led", {26'h0, led}, 32'h0000_003F);
    rd_chk("unmapped_24", 32'h0000_0024, 32'h0);
    rd_chk("unmapped_ffc", 32'h0000_0FFC, 32'h0);
    wr(32'h0000_0024, 32'hFFFF_FFFF);
    rd_chk("wr_unmapped_ignored", 32'h0000_0000, 32'h0000_003F);

    addr = 32'h0000_0000; wd = 32'h0000_002A; we = 1'b1;
    tick();
    we = 1'b0;
    check("rdw_old", rd, 32'h0000_003F);
    check("rdw_led", {26'h0, led}, 32'h0000_002A);
    tick();
    check("rdw_new", rd, 32'h0000_002A);
    wr(32'h0000_1000, 32'h0000_0015);
    check("alias_write", {26'h0, led}, 32'h0000_0015);
    rd_chk("alias_read", 32'hABCD_2003, 32'h0000_0015);

    addr = 32'h0000_0018;
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_rst_led", {26'h0, led}, 32'h0);
    check("async_rst_rd", rd, 32'h0);
    check("async_rst_gpio1", gpio1_w, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;
    wr(32'h0000_0000, 32'h0000_0009);
    check("post_rst_write", {26'h0, led}, 32'h0000_0009);
    rd_chk("post_rst_g1out", 32'h0000_0018, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
